dram_req_arbiter: RTL and testbench

- Two-requester arbiter in front of the DRAM controller FSM command interface (chip enable, read/write select, address, write data, byte write-enable, finish, address-ack, read-data-valid, write-done, idle).
- Requester 0 is the AXI DRAM slave FSM; requester 1 is the DMA engine.
- Grants whole transactions with round-robin priority, locks the grant until the last beat completes, waits for the controller to return to idle, and releases a stalled owner via a watchdog.

---
 rtl/dram_req_arbiter.sv | 110 +++++++++++
 tb/tb_dram_req_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter: round-robin two-requester transaction arbiter with a stall watchdog, placed in front of the DRAM controller command port (req* in, gnt/ack/rvalid/wdone/to_err out, controller signals muxed from the owner)
module dram_req_arbiter #(
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 32,
  parameter int IDLE_TO = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_we,
  input  logic [1:0]        req_last,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [3:0]        req0_wen,
  input  logic [3:0]        req1_wen,
  output logic [1:0]        gnt,
  output logic [1:0]        ack,
  output logic [1:0]        rvalid,
  output logic [1:0]        wdone,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        to_err,
  output logic              chip_enable,
  output logic              read_write_sel,
  output logic [ADDR_W-1:0] R_W_addr,
  output logic [DATA_W-1:0] write_data,
  output logic [3:0]        WEn_to_DRAM_FSM,
  output logic              R_W_finish,
  input  logic              get_addr,
  input  logic              read_data_valid,
  input  logic [DATA_W-1:0] read_data,
  input  logic              DRAM_write_done,
  input  logic              DRAM_idle
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;
  localparam int CW = $clog2(IDLE_TO + 1);
  logic [1:0]    state_q, state_d, gnt_q, gnt_d, own_oh;
  logic          owner_q, owner_d, rr_q, rr_d, last_we_q, last_we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_grant, routed, sel_valid, stall, fire, last_acc, done_now, done_drain, winner;
  always_comb begin
    in_grant   = state_q == S_GRANT;
    routed     = in_grant | (state_q == S_DRAIN);
    own_oh     = owner_q ? 2'b10 : 2'b01;
    sel_valid  = req_valid[owner_q];
    stall      = in_grant & ~sel_valid & ~get_addr & ~read_data_valid & ~DRAM_write_done;
    fire       = stall && (cnt_q == CW'(IDLE_TO - 1));
    last_acc   = in_grant & get_addr & sel_valid & req_last[owner_q];
    done_now   = last_acc & (req_we[owner_q] ? DRAM_write_done : read_data_valid);
    done_drain = (state_q == S_DRAIN) & (last_we_q ? DRAM_write_done : read_data_valid);
    winner     = req_valid[rr_q] ? rr_q : ~rr_q;
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    last_we_d  = last_we_q;
    case (state_q)
      S_IDLE: if (DRAM_idle && |req_valid) begin
        owner_d = winner;
        state_d = S_GRANT;
      end
      S_GRANT: if (done_now || fire) begin
        rr_d    = ~owner_q;
        state_d = S_WAIT;
      end else if (last_acc) begin
        last_we_d = req_we[owner_q];
        state_d   = S_DRAIN;
      end
      S_DRAIN: if (done_drain) begin
        rr_d    = ~owner_q;
        state_d = S_WAIT;
      end
      default: if (DRAM_idle) state_d = S_IDLE;
    endcase
    cnt_d = (stall && !fire) ? cnt_q + 1'b1 : '0;
    gnt_d = (state_d == S_GRANT || state_d == S_DRAIN) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      rr_q      <= 1'b0;
      last_we_q <= 1'b0;
      cnt_q     <= '0;
      gnt_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      last_we_q <= last_we_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
    end
  end
  assign gnt             = gnt_q;
  assign ack             = (routed && get_addr) ? own_oh : 2'b00;
  assign rvalid          = (routed && read_data_valid) ? own_oh : 2'b00;
  assign wdone           = (routed && DRAM_write_done) ? own_oh : 2'b00;
  assign to_err          = fire ? own_oh : 2'b00;
  assign rdata           = read_data;
  assign chip_enable     = in_grant & sel_valid;
  assign read_write_sel  = in_grant & req_we[owner_q];
  assign R_W_finish      = in_grant & sel_valid & req_last[owner_q];
  assign R_W_addr        = in_grant ? (owner_q ? req1_addr : req0_addr) : '0;
  assign write_data      = in_grant ? (owner_q ? req1_wdata : req0_wdata) : '0;
  assign WEn_to_DRAM_FSM = in_grant ? (owner_q ? req1_wen : req0_wen) : 4'hF;
endmodule

// File: tb/tb_dram_req_arbiter.sv
// tb_dram_req_arbiter: randomized check of dram_req_arbiter against a transaction-level reference model
module tb_dram_req_arbiter;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int TO = 16;
  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [1:0]    req_valid, req_we, req_last;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic [3:0]    req0_wen, req1_wen;
  logic [1:0]    gnt, ack, rvalid, wdone, to_err;
  logic [DW-1:0] rdata;
  logic          chip_enable, read_write_sel, R_W_finish;
  logic [AW-1:0] R_W_addr;
  logic [DW-1:0] write_data;
  logic [3:0]    WEn_to_DRAM_FSM;
  logic          get_addr, read_data_valid, DRAM_write_done, DRAM_idle;
  logic [DW-1:0] read_data;
  int total = 0;
  int bad = 0;
  int own, rr, stall_n, mode, wd_fires;
  bit drain, waiting, lwe;
  dram_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .IDLE_TO(TO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_we(req_we), .req_last(req_last),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
    .req0_wen(req0_wen), .req1_wen(req1_wen),
    .gnt(gnt), .ack(ack), .rvalid(rvalid), .wdone(wdone), .rdata(rdata), .to_err(to_err),
    .chip_enable(chip_enable), .read_write_sel(read_write_sel), .R_W_addr(R_W_addr),
    .write_data(write_data), .WEn_to_DRAM_FSM(WEn_to_DRAM_FSM), .R_W_finish(R_W_finish),
    .get_addr(get_addr), .read_data_valid(read_data_valid), .read_data(read_data),
    .DRAM_write_done(DRAM_write_done), .DRAM_idle(DRAM_idle)
  );
  always #5 ACLK = ~ACLK;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
    end
  endtask
  task automatic model_reset();
    own = -1;
    rr = 0;
    stall_n = 0;
    drain = 0;
    waiting = 0;
    lwe = 0;
  endtask
  function automatic bit stalled();
    return own >= 0 && !waiting && !drain && !req_valid[own] && !get_addr && !read_data_valid && !DRAM_write_done;
  endfunction
  task automatic check_all();
    bit active, granted;
    logic [1:0] oh;
    logic [61:0] e_ctrl;
    active  = own >= 0 && !waiting;
    granted = active && !drain;
    oh      = active ? 2'(1 << own) : 2'b00;
    e_ctrl  = {3'b000, {AW{1'b0}}, {DW{1'b0}}, 4'hF};
    if (granted)
      e_ctrl = {req_valid[own], req_we[own], req_valid[own] & req_last[own],
                own == 1 ? req1_addr : req0_addr, own == 1 ? req1_wdata : req0_wdata,
                own == 1 ? req1_wen : req0_wen};
    chk("gnt", 64'(gnt), 64'(oh));
    chk("ack", 64'(ack), 64'(get_addr ? oh : 2'b00));
    chk("rvalid", 64'(rvalid), 64'(read_data_valid ? oh : 2'b00));
    chk("wdone", 64'(wdone), 64'(DRAM_write_done ? oh : 2'b00));
    chk("to_err", 64'(to_err), 64'((stalled() && stall_n == TO - 1) ? oh : 2'b00));
    chk("rdata", 64'(rdata), 64'(read_data));
    chk("ctrl", 64'({chip_enable, read_write_sel, R_W_finish, R_W_addr, write_data, WEn_to_DRAM_FSM}), 64'(e_ctrl));
  endtask
  task automatic finish_txn();
    rr = 1 - own;
    own = -1;
    drain = 0;
    waiting = 1;
    stall_n = 0;
  endtask
  task automatic model_step();
    if (waiting) begin
      if (DRAM_idle) waiting = 0;
    end else if (own < 0) begin
      if (DRAM_idle && req_valid != 2'b00) begin
        own = req_valid[rr] ? rr : 1 - rr;
        stall_n = 0;
      end
    end else if (drain) begin
      if (lwe ? DRAM_write_done : read_data_valid) finish_txn();
    end else if (get_addr && req_valid[own] && req_last[own]) begin
      if (req_we[own] ? DRAM_write_done : read_data_valid) finish_txn();
      else begin
        drain = 1;
        lwe = req_we[own];
      end
    end else if (stalled()) begin
      if (stall_n == TO - 1) begin
        wd_fires++;
        finish_txn();
      end else stall_n++;
    end else stall_n = 0;
  endtask
  function automatic logic one_in(input int n);
    return $urandom_range(0, n - 1) == 0;
  endfunction
  task automatic drive_random();
    int pv;
    pv = mode == 1 ? 32 : 2;
    req_valid       = {one_in(pv), one_in(pv)};
    req_we          = 2'($urandom);
    req_last        = mode == 0 ? 2'($urandom) : 2'b11;
    req0_addr       = AW'($urandom);
    req1_addr       = AW'($urandom);
    req0_wdata      = $urandom;
    req1_wdata      = $urandom;
    req0_wen        = 4'($urandom);
    req1_wen        = 4'($urandom);
    get_addr        = mode == 1 ? one_in(64) : one_in(2);
    read_data_valid = mode == 1 ? one_in(64) : one_in(3);
    DRAM_write_done = mode == 1 ? one_in(64) : one_in(3);
    read_data       = $urandom;
    DRAM_idle       = mode == 2 ? one_in(4) : !one_in(4);
  endtask
  initial begin
    wd_fires = 0;
    mode = 0;
    ARESET = 1'b1;
    drive_random();
    model_reset();
    repeat (2) @(negedge ACLK);
    #1;
    chk("rst_wen", 64'(WEn_to_DRAM_FSM), 64'h0F);
    check_all();
    ARESET = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge ACLK);
      if (i % 200 == 0) mode = $urandom_range(0, 2);
      drive_random();
      #1;
      check_all();
      if ((drain && one_in(40)) || one_in(800)) begin
        ARESET = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        ARESET = 1'b0;
      end
      @(posedge ACLK);
      model_step();
    end
    chk("watchdog_hit", 64'(wd_fires > 0), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
